// File: rtl/pl_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package pl_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/pl_sync_fifo.sv
// Synchronous FIFO with flush; head entry is visible combinationally from storage.
module pl_sync_fifo
    import pl_fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        do_pop   = pop && !empty;
        // A pop frees the slot the simultaneous push needs when full.
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pl_inst_prefetch_buffer.sv
// Instruction prefetcher: issues in-order bus reads, buffers responses, and
// discards responses belonging to fetch streams abandoned by a redirect.
module pl_inst_prefetch_buffer
    import pl_fetch_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        next_inst,
    output logic        inst_available,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_address,
    output logic        inst_read_enable,
    input  logic        inst_wait_req,
    input  logic        inst_valid,
    input  logic [31:0] inst_data
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 2);

    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [31:0]   fetch_pc;
    logic [31:0]   write_pc;
    logic          held_stale;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] occupancy;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    logic          accept;
    logic          held;
    logic          do_push;
    logic          do_pop;
    logic [OW-1:0] outstanding_nxt;
    logic [CW-1:0] occupancy_nxt;
    logic [31:0]   fetch_pc_nxt;
    logic          issue_nxt;

    always_comb begin
        accept  = inst_read_enable && !inst_wait_req;
        held    = inst_read_enable && inst_wait_req;
        do_push = inst_valid && !redirect && (discard == '0);
        do_pop  = next_inst && !fifo_empty && !redirect;

        push_entry.inst = inst_data;
        push_entry.pc   = write_pc;

        outstanding_nxt = outstanding + OW'(accept) - OW'(inst_valid);
        occupancy_nxt   = redirect ? '0 : occupancy + CW'(do_push) - CW'(do_pop);

        // A request held across a redirect carries the old address, so its
        // acceptance must not advance the already-redirected fetch_pc.
        if (redirect) begin
            fetch_pc_nxt = redirect_pc;
        end else if (accept && !held_stale) begin
            fetch_pc_nxt = next_pc(fetch_pc);
        end else begin
            fetch_pc_nxt = fetch_pc;
        end

        issue_nxt = !redirect
                 && (outstanding_nxt < OW'(MAX_OUTSTANDING))
                 && ((32'(outstanding_nxt) + 32'(occupancy_nxt)) < 32'(DEPTH));

        inst_available = !fifo_empty;
        inst           = head_entry.inst;
        inst_pc        = head_entry.pc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding      <= '0;
            discard          <= '0;
            fetch_pc         <= RESET_PC;
            write_pc         <= RESET_PC;
            held_stale       <= 1'b0;
            inst_read_enable <= 1'b0;
            inst_address     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            fetch_pc    <= fetch_pc_nxt;

            // Every read still owed by the bus, including one presented in
            // this cycle, belongs to the abandoned stream.
            if (redirect) begin
                discard  <= outstanding + OW'(inst_read_enable) - OW'(inst_valid);
                write_pc <= redirect_pc;
            end else begin
                if (inst_valid && (discard != '0)) begin
                    discard <= discard - OW'(1);
                end
                if (do_push) begin
                    write_pc <= next_pc(write_pc);
                end
            end

            if (redirect) begin
                held_stale <= held;
            end else if (accept) begin
                held_stale <= 1'b0;
            end

            if (!held) begin
                inst_read_enable <= issue_nxt;
                if (issue_nxt) begin
                    inst_address <= fetch_pc_nxt;
                end
            end
        end
    end

    pl_sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (do_push),
        .push_data (push_entry),
        .pop       (do_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    a_valid_without_request: assert property (
        @(posedge clock) disable iff (reset) !(inst_valid && (outstanding == '0))
    );

    a_push_when_full: assert property (
        @(posedge clock) disable iff (reset) !(do_push && fifo_full && !do_pop)
    );

endmodule

// File: tb/tb_pl_inst_prefetch_buffer.sv
// Directed and randomized checks of pl_inst_prefetch_buffer against a
// stream-level model: epochs for redirects, a bus response queue and an entry queue.
module tb_pl_inst_prefetch_buffer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;
    localparam logic [31:0] RST_PC  = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        next_inst = 1'b0;
    logic        inst_available;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_address;
    logic        inst_read_enable;
    logic        inst_wait_req = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst_data = '0;

    always #5 clock = ~clock;

    pl_inst_prefetch_buffer #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (RST_PC)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .next_inst        (next_inst),
        .inst_available   (inst_available),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .inst_address     (inst_address),
        .inst_read_enable (inst_read_enable),
        .inst_wait_req    (inst_wait_req),
        .inst_valid       (inst_valid),
        .inst_data        (inst_data)
    );

    typedef struct {
        logic [31:0] addr;
        int          tag;
        int          due;
    } bus_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          epoch = 0;
    int          n_acc = 0;
    int          n_pops = 0;
    bus_t        bq[$];
    logic [31:0] mq[$];
    logic [31:0] popped_q[$];
    logic [31:0] cur_req;
    logic [31:0] pend_req;
    logic        stale = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        s_re, s_avail;
    logic [31:0] s_addr, s_inst, s_pc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b1;
        redirect      = 1'b0;
        next_inst     = 1'b0;
        inst_wait_req = 1'b0;
        inst_valid    = 1'b0;
        #1;
        chk("rst_re", inst_read_enable, 0);
        chk("rst_avail", inst_available, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_addr", inst_address, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bq.delete();
        mq.delete();
        popped_q.delete();
        epoch++;
        cur_req    = RST_PC;
        stale      = 1'b0;
        prev_stall = 1'b0;
        last_due   = cyc;
    endtask

    // One clock cycle: sample and check at negedge, drive inputs, advance the model.
    task automatic step(input logic wq, input logic rd, input logic [31:0] rpc,
                        input logic nx, input int lat);
        logic vld;
        logic acc;
        bus_t b;
        int   due;
        @(negedge clock);
        s_re    = inst_read_enable;
        s_addr  = inst_address;
        s_avail = inst_available;
        s_inst  = inst;
        s_pc    = inst_pc;

        chk("avail", s_avail, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("inst_pc", s_pc, mq[0]);
            chk("inst", s_inst, data_of(mq[0]));
        end
        if (prev_stall) begin
            chk("hold_re", s_re, 1);
            chk("hold_addr", s_addr, prev_addr);
        end
        chk("out_bound", bq.size() <= MAX_OUT, 1);
        chk("occ_bound", bq.size() + mq.size() <= DEPTH, 1);

        vld = (bq.size() != 0) && (bq[0].due <= cyc);
        inst_wait_req = wq;
        redirect      = rd;
        redirect_pc   = rpc;
        next_inst     = nx;
        inst_valid    = vld;
        inst_data     = vld ? data_of(bq[0].addr) : $urandom;

        acc = s_re && !wq;
        if (vld) b = bq.pop_front();
        if (nx && (mq.size() != 0) && !rd) begin
            popped_q.push_back(mq.pop_front());
            n_pops++;
        end
        if (vld && (b.tag == epoch) && !rd) mq.push_back(b.addr);
        if (acc) begin
            chk("req_addr", s_addr, cur_req);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            bq.push_back('{addr: s_addr, tag: (stale ? -1 : epoch), due: due});
            n_acc++;
            if (stale) begin
                cur_req = pend_req;
                stale   = 1'b0;
            end else begin
                cur_req = cur_req + 32'd4;
            end
        end
        if (rd) begin
            mq.delete();
            epoch++;
            if (s_re && wq) begin
                stale    = 1'b1;
                pend_req = rpc;
            end else begin
                cur_req = rpc;
            end
        end
        prev_stall = s_re && wq;
        prev_addr  = s_addr;
        cyc++;
    endtask

    task automatic run_until_pops(input int want, input int budget);
        int k;
        k = 0;
        while ((popped_q.size() < want) && (k < budget)) begin
            step(1'b0, 1'b0, '0, 1'b1, 1);
            k++;
        end
        chk("pop_timeout", popped_q.size() >= want, 1);
    endtask

    initial begin
        int a0, p0;
        logic        wq, rd, nx;
        logic [31:0] rpc;

        // Streaming with a zero-wait bus and the core always consuming.
        do_reset();
        p0 = n_pops;
        step(1'b0, 1'b0, '0, 1'b1, 1);
        chk("first_req_re", s_re, 1);
        chk("first_req_addr", s_addr, RST_PC);
        repeat (11) step(1'b0, 1'b0, '0, 1'b1, 1);
        chk("stream_pops", n_pops - p0, 10);
        if (popped_q.size() >= 3) begin
            chk("stream_pc0", popped_q[0], 32'h0040_0000);
            chk("stream_pc1", popped_q[1], 32'h0040_0004);
            chk("stream_pc2", popped_q[2], 32'h0040_0008);
        end

        // Buffer fills to DEPTH, then one pop permits exactly one request.
        do_reset();
        a0 = n_acc;
        repeat (10) step(1'b0, 1'b0, '0, 1'b0, 1);
        chk("fill_acc", n_acc - a0, 4);
        chk("full_re", s_re, 0);
        step(1'b0, 1'b0, '0, 1'b1, 1);
        a0 = n_acc;
        repeat (8) step(1'b0, 1'b0, '0, 1'b0, 1);
        chk("refill_acc", n_acc - a0, 1);

        // Redirect with two reads outstanding.
        do_reset();
        step(1'b0, 1'b0, '0, 1'b0, 4);
        step(1'b0, 1'b0, '0, 1'b0, 4);
        step(1'b0, 1'b1, 32'h0000_1000, 1'b0, 4);
        run_until_pops(1, 30);
        if (popped_q.size() >= 1) chk("redir_first_pc", popped_q[0], 32'h0000_1000);

        // Redirect while a request is held by wait_req.
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1);
        step(1'b1, 1'b1, 32'h0000_2000, 1'b0, 1);
        step(1'b1, 1'b0, '0, 1'b0, 1);
        step(1'b0, 1'b0, '0, 1'b0, 1);
        chk("stall_addr", s_addr, RST_PC);
        step(1'b0, 1'b0, '0, 1'b0, 1);
        chk("post_stall_re", s_re, 1);
        chk("post_stall_addr", s_addr, 32'h0000_2000);
        run_until_pops(1, 30);
        if (popped_q.size() >= 1) chk("stall_first_pc", popped_q[0], 32'h0000_2000);

        // Redirect + next_inst + inst_valid together with 3 entries buffered.
        do_reset();
        repeat (4) step(1'b0, 1'b0, '0, 1'b0, 1);
        step(1'b0, 1'b1, 32'h0000_3000, 1'b1, 1);
        chk("pre_redir_avail", s_avail, 1);
        step(1'b0, 1'b0, '0, 1'b1, 1);
        chk("flush_avail", s_avail, 0);
        popped_q.delete();
        run_until_pops(1, 30);
        if (popped_q.size() >= 1) chk("flush_first_pc", popped_q[0], 32'h0000_3000);

        // Fetch address wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1);
        popped_q.delete();
        run_until_pops(2, 30);
        if (popped_q.size() >= 2) begin
            chk("wrap_pc0", popped_q[0], 32'hFFFF_FFFC);
            chk("wrap_pc1", popped_q[1], 32'h0000_0000);
        end

        // Randomized traffic with a reset dropped into the middle.
        do_reset();
        p0 = n_pops;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            wq  = ($urandom % 10) < 3;
            rd  = ($urandom % 40) == 0;
            rpc = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            nx  = ($urandom % 10) < 6;
            step(wq, rd, rpc, nx, int'($urandom_range(1, 4)));
        end
        chk("liveness", (n_pops - p0) > 300, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pl_inst_prefetch_buffer.md
PL_INST_PREFETCH_BUFFER -- requirements
Module: pl_inst_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: prefetch buffer entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter MAX_OUTSTANDING, default 2: maximum accepted but unreturned bus reads; SHALL be between 1 and DEPTH.
REQ-003 Parameter RESET_PC, default 32'h0040_0000: first fetch address after reset.
REQ-004 Ports SHALL be, clock and reset first:
  clock  in  1  sole clock, all state on rising edge
  reset  in  1  asynchronous, active-high reset
  redirect  in  1  flush buffer and restart fetch at redirect_pc
  redirect_pc  in  32  new fetch address, word-aligned
  next_inst  in  1  core consumes head entry this cycle
  inst_available  out  1  head entry valid
  inst  out  32  head instruction word
  inst_pc  out  32  address of head instruction
  inst_address  out  32  bus read address
  inst_read_enable  out  1  bus read request
  inst_wait_req  in  1  bus stall; request not accepted this cycle
  inst_valid  in  1  bus read data valid, in request order
  inst_data  in  32  bus read data

Function
REQ-005 A request SHALL be accepted in any cycle where inst_read_enable=1 and inst_wait_req=0.
REQ-006 While inst_wait_req=1, inst_read_enable and inst_address SHALL hold their values until acceptance.
REQ-007 A new request SHALL start only when outstanding < MAX_OUTSTANDING, outstanding + occupancy < DEPTH, and redirect=0.
REQ-008 On acceptance, fetch_pc SHALL advance by 4, wrapping modulo 2^32.
REQ-009 Responses SHALL be written to the buffer tail on inst_valid=1 with pc = write_pc; write_pc SHALL then advance by 4.
REQ-010 Latency SHALL be one cycle from the response write to inst_available=1; there is no bypass path.
REQ-011 inst_available SHALL equal buffer non-empty; inst and inst_pc SHALL be the head entry.
REQ-012 next_inst with inst_available=1 SHALL pop the head; next_inst on an empty buffer SHALL be ignored.
REQ-013 A simultaneous push and pop SHALL leave occupancy unchanged, including when the buffer is full.
REQ-014 The outstanding count SHALL increment on acceptance, decrement on inst_valid, and be unchanged when both occur in the same cycle.
REQ-015 On redirect:
  - buffer flushed; inst_available=0 next cycle
  - fetch_pc and write_pc set to redirect_pc
  - discard count set to current outstanding, plus 1 if a request is held stalled by inst_wait_req, minus 1 if inst_valid=1 this cycle
REQ-016 A response arriving while discard count > 0 SHALL be dropped and SHALL decrement the discard count; it SHALL NOT advance write_pc.
REQ-017 A response arriving in the redirect cycle itself SHALL be dropped.
REQ-018 redirect SHALL take priority over next_inst in the same cycle.
REQ-019 A request held stalled at redirect SHALL keep its old address until accepted, and its response SHALL be discarded.
REQ-020 The first request to redirect_pc SHALL be issued no earlier than the cycle after redirect.
REQ-021 A redirect asserted while the discard count is still > 0 SHALL be accumulated into the discard count, not lost.
REQ-022 Counter widths SHALL be $clog2(DEPTH+1) for occupancy and $clog2(MAX_OUTSTANDING+2) for outstanding and discard.
REQ-023 inst_valid with outstanding=0 is a bus protocol violation; an assertion SHALL flag it.

Reset
REQ-024 On reset, asynchronously:
  - buffer empty
  - outstanding and discard counts = 0
  - fetch_pc and write_pc = RESET_PC
  - inst_read_enable=0, inst_available=0
  - inst, inst_pc, inst_address = 0
REQ-025 Reset asserted mid-transaction SHALL abandon all in-flight reads.
REQ-026 The first request after reset release SHALL be issued on the first clock edge after release.

Structure
REQ-027 Package pl_fetch_pkg SHALL hold fetch_entry_t {inst[31:0], pc[31:0]} and the default RESET_PC constant.
REQ-028 Storage SHALL be a sub-module pl_sync_fifo, parametrised by DEPTH and entry type, exposing full, empty and count.
REQ-029 Request issue, outstanding and discard tracking, and redirect logic SHALL reside in pl_inst_prefetch_buffer.

Verification
REQ-030 Reset, zero-wait bus with 1-cycle read latency, next_inst held high -> inst_pc sequence 0x00400000, 0x00400004, 0x00400008, one entry per cycle in steady state.
REQ-031 next_inst=0, DEPTH=4 -> exactly 4 accepted requests; inst_read_enable=0 while full; one pop -> exactly one new request.
REQ-032 Two requests outstanding, redirect to 0x00001000 -> both responses dropped; first inst_pc=0x00001000.
REQ-033 inst_wait_req held high 3 cycles, redirect in 2nd cycle -> inst_address stays at old PC until accepted; its data is dropped; next request goes to redirect_pc.
REQ-034 redirect and next_inst same cycle with 3 entries, inst_valid also high -> buffer empty, response dropped, discard count correct.
REQ-035 redirect_pc=0xFFFFFFFC -> next inst_pc values 0xFFFFFFFC, then 0x00000000.
